id_ex_stage: RTL and testbench

- ID/EX pipeline register sitting directly upstream of the ALU.
- Captures decoded operands and control from the decode stage.
- Resolves data hazards with forwarding from EX/MEM and MEM/WB, and detects load-use hazards, inserting a bubble when one occurs.
- Drives the ALU operand, opcode and enable inputs, plus EX-stage control, to the EX/MEM stage.

---
 rtl/id_ex_stage.sv | 197 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU.
// Captures decoded operands and control, bypasses MEM/WB at capture time,
// forwards from EX/MEM and MEM/WB on the stored operands, and inserts a
// bubble on a load-use hazard.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_use_imm,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic [4:0]        id_rd_addr,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic [4:0]        exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [4:0]        memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [XLEN-1:0]   memwb_data,
  output logic [XLEN-1:0]   alu_src1,
  output logic [XLEN-1:0]   alu_src2,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_enable,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [XLEN-1:0]   ex_store_data,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic              ex_valid_q,   ex_valid_d;
  logic [4:0]        rs1_addr_q,   rs1_addr_d;
  logic [4:0]        rs2_addr_q,   rs2_addr_d;
  logic [XLEN-1:0]   rs1_data_q,   rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q,   rs2_data_d;
  logic [XLEN-1:0]   imm_q,        imm_d;
  logic              use_imm_q,    use_imm_d;
  logic [OP_W-1:0]   alu_op_q,     alu_op_d;
  logic [4:0]        rd_q,         rd_d;
  logic              reg_write_q,  reg_write_d;
  logic              mem_read_q,   mem_read_d;
  logic              mem_write_q,  mem_write_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

  logic              lu_hit;
  logic [XLEN-1:0]   fwd_rs1, fwd_rs2;

  // Load-use detection: a load in EX whose destination the decode instruction reads.
  always_comb begin
    lu_hit = 1'b0;
    if (ex_valid_q && mem_read_q && (rd_q != 5'd0) && id_valid) begin
      lu_hit = (id_rs1_used && (id_rs1_addr == rd_q)) ||
               (id_rs2_used && (id_rs2_addr == rd_q));
    end
  end

  assign load_use_stall = lu_hit;
  assign id_ready       = !ex_hold && !lu_hit;

  // Next-state: flush beats hold, hold beats bubble, otherwise capture decode.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (!ex_hold) begin
      if (lu_hit) begin
        ex_valid_d  = 1'b0;
        stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
        ex_valid_d  = id_valid;
        rs1_addr_d  = id_rs1_addr;
        rs2_addr_d  = id_rs2_addr;
        // The register file has not seen this cycle's writeback yet.
        rs1_data_d  = (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == id_rs1_addr))
                      ? memwb_data : id_rs1_data;
        rs2_data_d  = (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == id_rs2_addr))
                      ? memwb_data : id_rs2_data;
        imm_d       = id_imm;
        use_imm_d   = id_use_imm;
        alu_op_d    = id_alu_op;
        rd_d        = id_rd_addr;
        reg_write_d = id_reg_write;
        mem_read_d  = id_mem_read;
        mem_write_d = id_mem_write;
      end
    end
  end

  // Pipeline register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      alu_op_q    <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Operand forwarding: EX/MEM is newer than MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs1_addr_q))
      fwd_rs1 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs1_addr_q))
      fwd_rs1 = memwb_data;
    fwd_rs2 = rs2_data_q;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs2_addr_q))
      fwd_rs2 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs2_addr_q))
      fwd_rs2 = memwb_data;
  end

  // Output gating: an empty EX slot drives all zeros.
  always_comb begin
    alu_enable    = ex_valid_q;
    alu_src1      = '0;
    alu_src2      = '0;
    alu_op        = '0;
    ex_rd         = '0;
    ex_reg_write  = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_store_data = '0;
    if (ex_valid_q) begin
      alu_src1      = fwd_rs1;
      alu_src2      = use_imm_q ? imm_q : fwd_rs2;
      alu_op        = alu_op_q;
      ex_rd         = rd_q;
      ex_reg_write  = reg_write_q;
      ex_mem_read   = mem_read_q;
      ex_mem_write  = mem_write_q;
      ex_store_data = fwd_rs2;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: hazard-free issue, forwarding priority,
// load-use bubble, capture-time bypass, flush/hold, async reset, saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        id_rs1_used, id_rs2_used;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_use_imm;
  logic [3:0]  id_alu_op;
  logic [4:0]  id_rd_addr;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush, ex_hold;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_data;

  logic        id_ready, alu_enable, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
  logic [31:0] alu_src1, alu_src2, ex_store_data;
  logic [3:0]  alu_op;
  logic [4:0]  ex_rd;
  logic [15:0] stall_cnt;

  logic        s_id_ready, s_alu_enable, s_ex_reg_write, s_ex_mem_read, s_ex_mem_write, s_lus;
  logic [31:0] s_alu_src1, s_alu_src2, s_ex_store_data;
  logic [3:0]  s_alu_op;
  logic [4:0]  s_ex_rd;
  logic [1:0]  s_stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .OP_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush), .ex_hold(ex_hold),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_data(memwb_data),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op), .alu_enable(alu_enable),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
    .load_use_stall(load_use_stall), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.XLEN(32), .OP_W(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(s_id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush), .ex_hold(ex_hold),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_data(memwb_data),
    .alu_src1(s_alu_src1), .alu_src2(s_alu_src2), .alu_op(s_alu_op), .alu_enable(s_alu_enable),
    .ex_rd(s_ex_rd), .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read),
    .ex_mem_write(s_ex_mem_write), .ex_store_data(s_ex_store_data),
    .load_use_stall(s_lus), .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_instr(input logic v, input logic [4:0] r1, input logic u1, input logic [31:0] d1,
                          input logic [4:0] r2, input logic u2, input logic [31:0] d2,
                          input logic [31:0] imm, input logic ui, input logic [3:0] op,
                          input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs1_addr = r1; id_rs1_used = u1; id_rs1_data = d1;
    id_rs2_addr = r2; id_rs2_used = u2; id_rs2_data = d2;
    id_imm = imm; id_use_imm = ui; id_alu_op = op; id_rd_addr = rd;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    #1;
  endtask

  task automatic fwd_src(input logic [4:0] er, input logic ew, input logic [31:0] ed,
                         input logic [4:0] mr, input logic mw, input logic [31:0] md);
    exmem_rd = er; exmem_reg_write = ew; exmem_result = ed;
    memwb_rd = mr; memwb_reg_write = mw; memwb_data = md;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".en"},   {31'd0, alu_enable}, 32'd0);
    chk({tag, ".src1"}, alu_src1, 32'd0);
    chk({tag, ".src2"}, alu_src2, 32'd0);
    chk({tag, ".op"},   {28'd0, alu_op}, 32'd0);
    chk({tag, ".rd"},   {27'd0, ex_rd}, 32'd0);
    chk({tag, ".ctl"},  {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    chk({tag, ".sd"},   ex_store_data, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    id_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fwd_src(0, 0, 0, 0, 0, 0);
    step(); step();
    // Reset state
    chk_all_zero("rst");
    chk("rst.cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst.ready", {31'd0, id_ready}, 32'd1);
    chk("rst.lus", {31'd0, load_use_stall}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Hazard-free ADD x1 = x5 + x6
    id_instr(1, 5, 1, 10, 6, 1, 20, 0, 0, 4'd0, 1, 1, 0, 0);
    chk("add.ready_pre", {31'd0, id_ready}, 32'd1);
    step();
    chk("add.src1", alu_src1, 32'd10);
    chk("add.src2", alu_src2, 32'd20);
    chk("add.en", {31'd0, alu_enable}, 32'd1);
    chk("add.rd", {27'd0, ex_rd}, 32'd1);
    chk("add.rw", {31'd0, ex_reg_write}, 32'd1);
    chk("add.ready", {31'd0, id_ready}, 32'd1);

    // Forwarding priority on stored rs1=3 (data 5), rs2=4 (data 7)
    id_instr(1, 3, 1, 32'h5, 4, 1, 32'h7, 0, 0, 4'd2, 8, 1, 0, 0);
    step();
    ex_hold = 1'b1;
    id_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fwd_src(3, 1, 32'h11, 3, 1, 32'h22);
    chk("fwd.exmem_wins", alu_src1, 32'h11);
    fwd_src(3, 0, 32'h11, 3, 1, 32'h22);
    chk("fwd.memwb", alu_src1, 32'h22);
    fwd_src(0, 1, 32'h11, 0, 1, 32'h22);
    chk("fwd.x0_none", alu_src1, 32'h5);
    fwd_src(4, 1, 32'h44, 0, 0, 0);
    chk("fwd.rs2_src2", alu_src2, 32'h44);
    chk("fwd.rs2_sd", ex_store_data, 32'h44);
    fwd_src(0, 0, 0, 0, 0, 0);

    // ex_hold for 3 cycles with changing decode: outputs frozen
    for (int i = 0; i < 3; i++) begin
      id_instr(1, 5'(i + 20), 1, 32'(i + 100), 5'(i + 21), 1, 32'(i + 200), 0, 0, 4'(i + 5), 5'(i + 1), 1, 0, 1);
      chk("hold.ready", {31'd0, id_ready}, 32'd0);
      step();
      chk("hold.src1", alu_src1, 32'h5);
      chk("hold.src2", alu_src2, 32'h7);
      chk("hold.op", {28'd0, alu_op}, 32'd2);
      chk("hold.rd", {27'd0, ex_rd}, 32'd8);
      chk("hold.ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'b100);
    end
    ex_hold = 1'b0;

    // Load-use: LW x7 = [x2 + 4], then ADD x10 = x1 + x7
    id_instr(1, 2, 1, 32'h100, 0, 0, 0, 32'd4, 1, 4'd0, 7, 1, 1, 0);
    step();
    chk("lw.src1", alu_src1, 32'h100);
    chk("lw.imm", alu_src2, 32'd4);
    chk("lw.mr", {31'd0, ex_mem_read}, 32'd1);
    id_instr(1, 1, 1, 32'd1, 7, 1, 32'h33, 0, 0, 4'd0, 10, 1, 0, 0);
    chk("lu.stall", {31'd0, load_use_stall}, 32'd1);
    chk("lu.ready", {31'd0, id_ready}, 32'd0);
    step();
    chk("lu.bubble_en", {31'd0, alu_enable}, 32'd0);
    chk("lu.bubble_mr", {31'd0, ex_mem_read}, 32'd0);
    chk("lu.cnt", {16'd0, stall_cnt}, 32'd1);
    chk("lu.stall_once", {31'd0, load_use_stall}, 32'd0);
    chk("lu.ready_back", {31'd0, id_ready}, 32'd1);
    step();
    chk("lu.add_en", {31'd0, alu_enable}, 32'd1);
    chk("lu.add_src1", alu_src1, 32'd1);
    chk("lu.add_src2", alu_src2, 32'h33);
    chk("lu.add_rd", {27'd0, ex_rd}, 32'd10);

    // Capture-time bypass: MEM/WB writes x9 while decode reads stale x9
    id_instr(1, 9, 1, 32'd0, 0, 0, 0, 0, 0, 4'd0, 11, 1, 0, 0);
    fwd_src(0, 0, 0, 9, 1, 32'hDEAD);
    step();
    fwd_src(0, 0, 0, 0, 0, 0);
    id_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("byp.src1", alu_src1, 32'hDEAD);

    // Flush with hold while EX holds a valid SUB
    id_instr(1, 1, 1, 32'd50, 2, 1, 32'd8, 0, 0, 4'd1, 12, 1, 0, 0);
    step();
    chk("sub.op", {28'd0, alu_op}, 32'd1);
    chk("sub.en", {31'd0, alu_enable}, 32'd1);
    flush = 1'b1; ex_hold = 1'b1; #1;
    step();
    flush = 1'b0; ex_hold = 1'b0;
    id_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_all_zero("flush");

    // Five more load-use stalls: wide counter reaches 6, 2-bit counter sticks at 3
    for (int i = 0; i < 5; i++) begin
      id_instr(1, 2, 1, 32'h100, 0, 0, 0, 32'd4, 1, 4'd0, 7, 1, 1, 0);
      step();
      id_instr(1, 7, 1, 32'd0, 0, 0, 0, 0, 0, 4'd0, 10, 1, 0, 0);
      step();
    end
    chk("sat.wide", {16'd0, stall_cnt}, 32'd6);
    chk("sat.narrow", {30'd0, s_stall_cnt}, 32'd3);

    // A stall under ex_hold does not count
    id_instr(1, 2, 1, 32'h100, 0, 0, 0, 32'd4, 1, 4'd0, 7, 1, 1, 0);
    step();
    id_instr(1, 7, 1, 32'd0, 0, 0, 0, 0, 0, 4'd0, 10, 1, 0, 0);
    ex_hold = 1'b1; #1;
    chk("hstall.lus", {31'd0, load_use_stall}, 32'd1);
    step();
    chk("hstall.cnt", {16'd0, stall_cnt}, 32'd6);
    chk("hstall.lw_kept", {31'd0, ex_mem_read}, 32'd1);
    ex_hold = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;

    // Async reset mid-cycle with a valid instruction in EX
    id_instr(1, 5, 1, 32'd77, 6, 1, 32'd88, 0, 0, 4'd3, 13, 1, 0, 1);
    step();
    chk("pre_rst.en", {31'd0, alu_enable}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    chk("arst.cnt", {16'd0, stall_cnt}, 32'd0);
    chk("arst.cnt_narrow", {30'd0, s_stall_cnt}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
